// File: rtl/adc_dac_sequencer.sv
// Per-period scheduler: one ADC frame, one DAC frame carrying the fresh sample, then an ldac pulse.
// Optional feature macro: ADC_CHANNEL_CHECK_EN adds the sticky channelError output.
module adc_dac_sequencer #(
    parameter int         FRAME_PERIOD = 100,
    parameter int         GAP_CYCLES   = 2,
    parameter logic [3:0] DAC_CTRL     = 4'b0011
) (
    input  logic        serialClock,
    input  logic        reset,
    input  logic        enable,
    input  logic [7:0]  channelMask,
    input  logic        adcDataOut,
    output logic        syncADC,
    output logic        adcDataIn,
    output logic        syncDAC,
    output logic        dacDataIn,
    output logic        ldac,
    output logic [11:0] sampleData,
    output logic [2:0]  sampleChannel,
    output logic        sampleValid,
`ifdef ADC_CHANNEL_CHECK_EN
    output logic        channelError,
`endif
    output logic        busy
);

    localparam int                PC_W     = $clog2(FRAME_PERIOD);
    localparam logic [PC_W-1:0]   PC_LAST  = PC_W'(FRAME_PERIOD - 1);
    localparam int                CNT_W    = (GAP_CYCLES > 16) ? $clog2(GAP_CYCLES) : 4;
    localparam logic [CNT_W-1:0]  BIT_LAST = CNT_W'(15);
    localparam logic [CNT_W-1:0]  GAP_LAST = CNT_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, ADC_SHIFT, GAP, DAC_SHIFT, LOAD, WAIT} state_t;

    function automatic logic [15:0] adc_ctrl_word(input logic [2:0] ch);
        return {3'b100, ch, 2'b11, 4'b0011, 4'b0000};
    endfunction

    state_t            r_state;
    logic [PC_W-1:0]   r_pc;
    logic [CNT_W-1:0]  r_cnt;
    logic [2:0]        r_ch;
    logic [13:0]       r_adc_shift;
    logic              r_sync_adc, r_adc_di, r_sync_dac, r_dac_di, r_ldac;
    logic [11:0]       r_sample_data;
    logic [2:0]        r_sample_channel;
    logic              r_sample_valid, r_busy;

    logic [7:0]        w_rot;
    logic [2:0]        w_next_ch;
    logic [15:0]       w_adc_word, w_adc_word_next, w_dac_word;
    logic [14:0]       w_captured;
    logic              w_start;

    // w_rot[gi] is the mask bit gi+1 positions above the current pointer.
    for (genvar gi = 0; gi < 8; gi++) begin : g_rot
        assign w_rot[gi] = channelMask[r_ch + 3'(gi + 1)];
    end

    always_comb begin
        w_next_ch = r_ch;
        for (int i = 7; i >= 0; i--) begin
            if (w_rot[i]) w_next_ch = r_ch + 3'(i + 1);
        end
    end

    assign w_adc_word      = adc_ctrl_word(r_ch);
    assign w_adc_word_next = adc_ctrl_word(w_next_ch);
    assign w_dac_word      = {DAC_CTRL, r_sample_data};
    // Bit 15 of the ADC result is never needed, so only 15 bits are kept.
    assign w_captured      = {r_adc_shift, adcDataOut};
    assign w_start         = (r_pc == '0) && enable && (channelMask != 8'h00);

`ifdef ADC_CHANNEL_CHECK_EN
    logic [2:0] r_prev_ch;
    logic       r_check, r_have_prev, r_channel_error;
    assign channelError = r_channel_error;
`endif

    always_ff @(posedge serialClock) begin
        if (reset) begin
            r_state          <= IDLE;
            r_pc             <= '0;
            r_cnt            <= '0;
            r_ch             <= 3'd7;
            r_adc_shift      <= '0;
            r_sync_adc       <= 1'b1;
            r_adc_di         <= 1'b0;
            r_sync_dac       <= 1'b1;
            r_dac_di         <= 1'b0;
            r_ldac           <= 1'b1;
            r_sample_data    <= '0;
            r_sample_channel <= '0;
            r_sample_valid   <= 1'b0;
            r_busy           <= 1'b0;
`ifdef ADC_CHANNEL_CHECK_EN
            r_prev_ch        <= '0;
            r_check          <= 1'b0;
            r_have_prev      <= 1'b0;
            r_channel_error  <= 1'b0;
`endif
        end else begin
            r_sample_valid <= 1'b0;
            r_pc           <= (r_pc == PC_LAST) ? '0 : r_pc + 1'b1;
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_state    <= ADC_SHIFT;
                        r_ch       <= w_next_ch;
                        r_cnt      <= '0;
                        r_sync_adc <= 1'b0;
                        r_adc_di   <= w_adc_word_next[15];
                        r_busy     <= 1'b1;
`ifdef ADC_CHANNEL_CHECK_EN
                        r_prev_ch   <= r_ch;
                        r_check     <= r_have_prev;
                        r_have_prev <= 1'b1;
`endif
                    end
                end
                ADC_SHIFT: begin
                    r_adc_shift <= w_captured[13:0];
                    if (r_cnt == BIT_LAST) begin
                        r_state          <= GAP;
                        r_cnt            <= '0;
                        r_sync_adc       <= 1'b1;
                        r_adc_di         <= 1'b0;
                        r_sample_data    <= w_captured[11:0];
                        r_sample_channel <= w_captured[14:12];
                        r_sample_valid   <= 1'b1;
`ifdef ADC_CHANNEL_CHECK_EN
                        // The result belongs to the channel requested one frame earlier.
                        if (r_check && (w_captured[14:12] != r_prev_ch))
                            r_channel_error <= 1'b1;
`endif
                    end else begin
                        r_cnt    <= r_cnt + 1'b1;
                        r_adc_di <= w_adc_word[4'd14 - r_cnt[3:0]];
                    end
                end
                GAP: begin
                    if (r_cnt == GAP_LAST) begin
                        r_state    <= DAC_SHIFT;
                        r_cnt      <= '0;
                        r_sync_dac <= 1'b0;
                        r_dac_di   <= w_dac_word[15];
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DAC_SHIFT: begin
                    if (r_cnt == BIT_LAST) begin
                        r_state    <= LOAD;
                        r_sync_dac <= 1'b1;
                        r_dac_di   <= 1'b0;
                        r_ldac     <= 1'b0;
                    end else begin
                        r_cnt    <= r_cnt + 1'b1;
                        r_dac_di <= w_dac_word[4'd14 - r_cnt[3:0]];
                    end
                end
                LOAD: begin
                    r_ldac  <= 1'b1;
                    r_busy  <= 1'b0;
                    // Leave IDLE armed so it sees pc==0 on the very next edge.
                    r_state <= (r_pc == PC_LAST) ? IDLE : WAIT;
                end
                WAIT: begin
                    if (r_pc == PC_LAST) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign syncADC       = r_sync_adc;
    assign adcDataIn     = r_adc_di;
    assign syncDAC       = r_sync_dac;
    assign dacDataIn     = r_dac_di;
    assign ldac          = r_ldac;
    assign sampleData    = r_sample_data;
    assign sampleChannel = r_sample_channel;
    assign sampleValid   = r_sample_valid;
    assign busy          = r_busy;

endmodule
